// File: rtl/cpu_sequencer_if.sv
// Bus bundle between the instruction sequencer and its environment:
// run control, instruction/data memory handshakes, control-unit decode
// inputs, datapath strobes and status outputs.
interface cpu_sequencer_if #(
  parameter int CNT_W = 32
);
  logic             run;
  logic             imem_req;
  logic             imem_ack;
  logic             ir_write;
  logic [3:0]       opcode;
  logic             cu_mem_read;
  logic             cu_mem_write;
  logic             cu_reg_write;
  logic             cu_branch;
  logic             alu_zero;
  logic             dmem_req;
  logic             dmem_we;
  logic             dmem_ack;
  logic             reg_we;
  logic             pc_write;
  logic             pc_src;
  logic [2:0]       state;
  logic             bus_error;
  logic [CNT_W-1:0] instret;

  // Sequencer side: consumes decode/acks, produces requests and strobes.
  modport master (
    input  run, imem_ack, opcode, cu_mem_read, cu_mem_write, cu_reg_write,
           cu_branch, alu_zero, dmem_ack,
    output imem_req, ir_write, dmem_req, dmem_we, reg_we, pc_write, pc_src,
           state, bus_error, instret
  );

  // Environment side: memories, control unit and datapath.
  modport slave (
    output run, imem_ack, opcode, cu_mem_read, cu_mem_write, cu_reg_write,
           cu_branch, alu_zero, dmem_ack,
    input  imem_req, ir_write, dmem_req, dmem_we, reg_we, pc_write, pc_src,
           state, bus_error, instret
  );
endinterface

// File: rtl/cpu_sequencer.sv
// Multi-cycle instruction sequencer: steps each instruction through
// FETCH/DECODE/EXEC/MEM/WB, converts static decode signals into one-cycle
// strobes, runs the imem/dmem req/ack handshakes with a bounded wait and
// counts retired instructions.
module cpu_sequencer #(
  parameter int CNT_W   = 32,
  parameter int TIMEOUT = 15
) (
  input  logic             clk,
  input  logic             rst,
  cpu_sequencer_if.master  bus
);

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_FETCH  = 3'd1;
  localparam logic [2:0] S_DECODE = 3'd2;
  localparam logic [2:0] S_EXEC   = 3'd3;
  localparam logic [2:0] S_MEM    = 3'd4;
  localparam logic [2:0] S_WB     = 3'd5;
  localparam logic [2:0] S_ERROR  = 3'd6;

  // Wait counter holds 0..TIMEOUT-1: the number of unacked request cycles
  // already spent in the current FETCH or MEM visit.
  localparam int                WAIT_W    = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT);
  localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(TIMEOUT - 1);

  logic [2:0]        r_state;
  logic [WAIT_W-1:0] r_wait_cnt;
  logic              r_bus_error;
  logic [CNT_W-1:0]  r_instret;

  logic [2:0]        w_next_state;
  logic [WAIT_W-1:0] w_wait_next;
  logic              w_retire;
  logic              w_imem_req;
  logic              w_ir_write;
  logic              w_dmem_req;
  logic              w_dmem_we;
  logic              w_reg_we;
  logic              w_pc_write;
  logic              w_pc_src;
  logic              w_mem_op;
  logic              w_unused;

  assign w_mem_op = bus.cu_mem_read | bus.cu_mem_write;
  // The opcode is carried for visibility only; the decode arrives pre-digested.
  assign w_unused = ^bus.opcode;

  // Next-state, wait-counter and strobe decode from the current state.
  always_comb begin
    // NOTE: every output of this block gets a default before the case so no
    // path leaves a value unassigned, which would otherwise infer a latch.
    w_next_state = r_state;
    w_wait_next  = '0;
    w_retire     = 1'b0;
    w_imem_req   = 1'b0;
    w_ir_write   = 1'b0;
    w_dmem_req   = 1'b0;
    w_dmem_we    = 1'b0;
    w_reg_we     = 1'b0;
    w_pc_write   = 1'b0;
    w_pc_src     = 1'b0;

    case (r_state)
      S_IDLE: begin
        if (bus.run) w_next_state = S_FETCH;
      end

      S_FETCH: begin
        w_imem_req = 1'b1;
        if (bus.imem_ack) begin
          w_ir_write   = 1'b1;
          w_next_state = S_DECODE;
        end else if (r_wait_cnt == WAIT_LAST) begin
          w_next_state = S_ERROR;
        end else begin
          w_wait_next = r_wait_cnt + 1'b1;
        end
      end

      S_DECODE: w_next_state = S_EXEC;

      S_EXEC: begin
        if (bus.cu_branch) begin
          w_pc_write = 1'b1;
          w_pc_src   = bus.alu_zero;
          w_retire   = 1'b1;
        end else if (w_mem_op) begin
          w_next_state = S_MEM;
        end else if (bus.cu_reg_write) begin
          w_next_state = S_WB;
        end else begin
          // Unknown opcode: just advance the PC.
          w_pc_write = 1'b1;
          w_retire   = 1'b1;
        end
      end

      S_MEM: begin
        w_dmem_req = 1'b1;
        // A read decode wins over a simultaneous write decode.
        w_dmem_we  = bus.cu_mem_write & ~bus.cu_mem_read;
        if (bus.dmem_ack) begin
          if (bus.cu_mem_read) begin
            w_next_state = S_WB;
          end else begin
            w_pc_write = 1'b1;
            w_retire   = 1'b1;
          end
        end else if (r_wait_cnt == WAIT_LAST) begin
          w_next_state = S_ERROR;
        end else begin
          w_wait_next = r_wait_cnt + 1'b1;
        end
      end

      S_WB: begin
        w_reg_we   = 1'b1;
        w_pc_write = 1'b1;
        w_retire   = 1'b1;
      end

      S_ERROR: w_next_state = S_ERROR;

      default: w_next_state = S_IDLE;
    endcase

    // run is only looked at on the retire cycle (and in IDLE above).
    if (w_retire) w_next_state = bus.run ? S_FETCH : S_IDLE;
  end

  // State, wait counter, sticky error flag and retire counter.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values regardless of statement order.
    if (rst) begin
      r_state     <= S_IDLE;
      r_wait_cnt  <= '0;
      r_bus_error <= 1'b0;
      r_instret   <= '0;
    end else begin
      r_state    <= w_next_state;
      r_wait_cnt <= w_wait_next;
      if (w_next_state == S_ERROR) r_bus_error <= 1'b1;
      if (w_retire)                r_instret   <= r_instret + 1'b1;
    end
  end

  assign bus.imem_req  = w_imem_req;
  assign bus.ir_write  = w_ir_write;
  assign bus.dmem_req  = w_dmem_req;
  assign bus.dmem_we   = w_dmem_we;
  assign bus.reg_we    = w_reg_we;
  assign bus.pc_write  = w_pc_write;
  assign bus.pc_src    = w_pc_src;
  assign bus.state     = r_state;
  assign bus.bus_error = r_bus_error;
  assign bus.instret   = r_instret;

endmodule

// File: tb/tb_cpu_sequencer.sv
// Self-checking bench for cpu_sequencer: random instruction classes and ack
// delays scored against a per-instruction transaction model, plus directed
// reset-in-flight, timeout and counter-wrap scenarios.
module tb_cpu_sequencer;

  localparam int CNT_W   = 4;
  localparam int TIMEOUT = 15;
  localparam int NEVER   = TIMEOUT + 1;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  cpu_sequencer_if #(.CNT_W(CNT_W)) bus ();

  cpu_sequencer #(.CNT_W(CNT_W), .TIMEOUT(TIMEOUT)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.master)
  );

  int n_vec;
  int n_err;
  int m_instret;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    bus.run          = 1'b0;
    bus.imem_ack     = 1'b0;
    bus.dmem_ack     = 1'b0;
    bus.opcode       = 4'h0;
    bus.cu_mem_read  = 1'b0;
    bus.cu_mem_write = 1'b0;
    bus.cu_reg_write = 1'b0;
    bus.cu_branch    = 1'b0;
    bus.alu_zero     = 1'b0;
  endtask

  task automatic do_reset();
    clear_inputs();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    m_instret = 0;
    check("rst_state", bus.state, 0);
    check("rst_instret", bus.instret, 0);
    check("rst_bus_error", bus.bus_error, 0);
    check("rst_imem_req", bus.imem_req, 0);
  endtask

  // From IDLE: raise run for one cycle so the next cycle is FETCH.
  task automatic kick();
    bus.run = 1'b1;
    #1;
    check("kick_idle", bus.state, 0);
    tick();
    bus.run = 1'b0;
  endtask

  task automatic idle_check(input int cycles);
    bus.run = 1'b0;
    for (int i = 0; i < cycles; i++) begin
      #1;
      check("idle_state", bus.state, 0);
      check("idle_no_imem_req", bus.imem_req, 0);
      tick();
    end
  endtask

  // One instruction starting in FETCH. di/dm are the request cycle on which
  // the ack arrives (NEVER = no ack). The model predicts the outcome from the
  // instruction class alone.
  task automatic do_instr(input logic br, input logic rd, input logic wr, input logic rg,
                          input logic zero, input int di, input int dm,
                          input logic run_after, output bit err);
    int  exp_len, exp_rw, exp_dc, exp_dwe, exp_psrc;
    int  n, ic, dc, dwe, rw, pw, irw, irw_bad, psrc;
    bit  retired, saw_err;

    // Reference model.
    err = 1'b0; exp_rw = 0; exp_dc = 0; exp_dwe = 0; exp_psrc = 0;
    if (di > TIMEOUT) begin
      err = 1'b1; exp_len = TIMEOUT;
    end else if (br) begin
      exp_len = di + 2; exp_psrc = int'(zero);
    end else if (rd || wr) begin
      if (dm > TIMEOUT) begin
        err = 1'b1; exp_len = di + 2 + TIMEOUT; exp_dc = TIMEOUT;
        exp_dwe = rd ? 0 : TIMEOUT;
      end else if (rd) begin
        exp_len = di + 3 + dm; exp_rw = 1; exp_dc = dm;
      end else begin
        exp_len = di + 2 + dm; exp_dc = dm; exp_dwe = dm;
      end
    end else if (rg) begin
      exp_len = di + 3; exp_rw = 1;
    end else begin
      exp_len = di + 2;
    end

    bus.cu_branch    = br;
    bus.cu_mem_read  = rd;
    bus.cu_mem_write = wr;
    bus.cu_reg_write = rg;
    bus.alu_zero     = zero;
    bus.opcode       = 4'($urandom_range(0, 15));

    n = -1; ic = 0; dc = 0; dwe = 0; rw = 0; pw = 0; irw = 0; irw_bad = 0; psrc = 0;
    saw_err = 1'b0;
    for (int cyc = 0; cyc < 60; cyc++) begin
      // Acks answer outstanding requests; outside a request they are noise.
      bus.imem_ack = bus.imem_req ? (ic + 1 == di) : 1'($urandom_range(0, 1));
      bus.dmem_ack = bus.dmem_req ? (dc + 1 == dm) : 1'($urandom_range(0, 1));
      bus.run      = (!err && cyc == exp_len - 1) ? run_after : 1'($urandom_range(0, 1));
      #1;
      if (bus.state == 3'd6) begin
        saw_err = 1'b1; n = cyc;
        break;
      end
      if (bus.imem_req) ic++;
      if (bus.ir_write) begin
        irw++;
        if (!bus.imem_ack) irw_bad++;
      end
      if (bus.dmem_req) begin
        dc++;
        if (bus.dmem_we) dwe++;
      end
      if (bus.reg_we) rw++;
      retired = bus.pc_write;
      if (retired) begin
        pw++; psrc = int'(bus.pc_src);
      end
      tick();
      if (retired) begin
        n = cyc + 1;
        break;
      end
    end
    bus.run = run_after;

    check("len", n, exp_len);
    check("ended_in_error", saw_err, err);
    check("dmem_req_cycles", dc, exp_dc);
    check("dmem_we_cycles", dwe, exp_dwe);
    check("reg_we", rw, exp_rw);
    check("ir_write_w_ack", irw_bad, 0);
    if (err) begin
      check("err_pc_write", pw, 0);
      check("err_bus_error", bus.bus_error, 1);
      check("err_instret", bus.instret, m_instret);
      tick();
      check("err_held", bus.state, 6);
      check("err_no_req", bus.imem_req | bus.dmem_req, 0);
    end else begin
      m_instret = (m_instret + 1) % (1 << CNT_W);
      check("ir_write", irw, 1);
      check("pc_write", pw, 1);
      check("pc_src", psrc, exp_psrc);
      check("instret", bus.instret, m_instret);
      check("next_state", bus.state, run_after ? 1 : 0);
    end
  endtask

  task automatic recover(input bit err, input logic run_after);
    if (err) begin
      do_reset();
      kick();
    end else if (!run_after) begin
      idle_check(2);
      kick();
    end
  endtask

  function automatic int pick_delay();
    int r;
    r = $urandom_range(0, 99);
    if (r < 40) return 1;
    if (r < 50) return TIMEOUT;
    if (r < 53) return NEVER;
    return $urandom_range(1, TIMEOUT);
  endfunction

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    bit   err;
    logic br, rd, wr, rg, zero, ra;
    int   k, di, dm;

    n_vec = 0;
    n_err = 0;
    m_instret = 0;
    clear_inputs();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    do_reset();
    kick();

    // ADD, zero-wait.
    do_instr(0, 0, 0, 1, 0, 1, 1, 1, err);
    // LOAD with ack on the 3rd dmem request cycle.
    do_instr(0, 1, 0, 1, 0, 1, 3, 1, err);
    // BRANCH taken and not taken.
    do_instr(1, 0, 0, 0, 1, 1, 1, 1, err);
    do_instr(1, 0, 0, 0, 0, 1, 1, 1, err);
    // STORE acked on the last allowed cycle, then a NOP, then run drop.
    do_instr(0, 0, 1, 0, 0, 1, TIMEOUT, 1, err);
    do_instr(0, 0, 0, 0, 0, 1, 1, 0, err);
    recover(err, 1'b0);
    // STORE that never gets its ack.
    do_instr(0, 0, 1, 0, 0, 1, NEVER, 1, err);
    recover(err, 1'b1);

    // Randomized mix.
    for (int t = 0; t < 80; t++) begin
      br = 0; rd = 0; wr = 0; rg = 0;
      k = $urandom_range(0, 4);
      case (k)
        0: begin br = 1; rd = 1'($urandom_range(0, 1)); wr = 1'($urandom_range(0, 1));
                 rg = 1'($urandom_range(0, 1)); end
        1: begin rd = 1; wr = 1'($urandom_range(0, 1)); rg = 1'($urandom_range(0, 1)); end
        2: begin wr = 1; rg = 1'($urandom_range(0, 1)); end
        3: rg = 1;
        default: ;
      endcase
      zero = 1'($urandom_range(0, 1));
      di   = pick_delay();
      dm   = pick_delay();
      ra   = ($urandom_range(0, 3) != 0);
      do_instr(br, rd, wr, rg, zero, di, dm, ra, err);
      recover(err, ra);
    end

    // Reset while a load waits in MEM.
    bus.cu_mem_read = 1'b1; bus.cu_mem_write = 1'b0;
    bus.cu_reg_write = 1'b1; bus.cu_branch = 1'b0;
    bus.imem_ack = 1'b1; bus.dmem_ack = 1'b0; bus.run = 1'b1;
    tick();
    bus.imem_ack = 1'b0;
    tick();
    tick();
    for (int i = 0; i < 4; i++) begin
      #1;
      check("mem_wait_req", bus.dmem_req, 1);
      tick();
    end
    rst = 1'b1;
    tick();
    rst = 1'b0;
    m_instret = 0;
    check("midmem_state", bus.state, 0);
    check("midmem_dmem_req", bus.dmem_req, 0);
    check("midmem_instret", bus.instret, 0);
    check("midmem_bus_error", bus.bus_error, 0);

    // Sixteen NOPs wrap the counter back to zero; run drops on the last.
    kick();
    for (int i = 0; i < 16; i++) begin
      do_instr(0, 0, 0, 0, 0, 1, 1, (i != 15), err);
    end
    check("wrap_instret", bus.instret, 0);
    idle_check(3);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
